multi_digit_ssd: RTL
====================

# multi_digit_ssd

Parametrised, time-multiplexed seven-segment display driver for N digits (default 8) on the board's common-anode display. Adds a valid/ready load port with tear-free frame-boundary update, per-digit decimal points, blanking, blinking, leading-zero suppression and PWM brightness. It sits between the debug/status logic (register snapshots, PC, cycle counts) and the board SSD pins.

## Interface
- NUM_DIGITS, 8, digits driven; legal 1..16
- CYCLE_PER_DIGIT, 100000, clk cycles per digit slot; legal >= 2
- BRIGHT_W, 4, brightness input width
- BLINK_FRAMES, 64, frames per blink half-period; legal >= 1
- clk  in  1  clock
- rstn  in  1  reset: synchronous, active-low
- in_valid  in  1  load request
- in_ready  out  1  load accepted when in_valid & in_ready
- in_value  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i (digit 0 rightmost)
- in_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_mask  in  NUM_DIGITS  1 = digit always dark (live)
- blink_mask  in  NUM_DIGITS  1 = digit blinks (live)
- lz_suppress  in  1  leading-zero suppression enable (live)
- brightness  in  BRIGHT_W  0 = off, all-ones = full on (live)
- dout  out  7  segments g..a (bit6 = g), active-low
- dp_n  out  1  decimal point, active-low
- sel  out  NUM_DIGITS  digit anodes, active-low, at most one low
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- Registers: pend_val/pend_dp + pending flag; act_val/act_dp (displayed); slot counter cnt (0..CYCLE_PER_DIGIT-1); digit index idx (0..NUM_DIGITS-1); free-running pwm_cnt (BRIGHT_W bits); blink frame counter; blink phase bit.
- in_ready = ~pending (combinational from register). Accept: pend_* <= inputs, pending <= 1.
- cnt increments every cycle, wraps at CYCLE_PER_DIGIT-1; on wrap idx advances, NUM_DIGITS-1 wraps to 0.
- Frame boundary = cnt wrap with idx == NUM_DIGITS-1. At boundary: frame_done pulses; if pending, act_* <= pend_*, pending <= 0; blink counter advances, toggling phase and clearing after BLINK_FRAMES boundaries.
- Accept and boundary in same cycle impossible with pending = 1 (in_ready low); with pending = 0, new value is latched and copied at the next boundary, not this one.
- Digit idx is dark if: blank_mask[idx]; or blink_mask[idx] & phase; or lz_suppress & idx != 0 & act nibbles idx..NUM_DIGITS-1 all zero. Dark: dout = 7'h7F, dp_n = 1, sel still drives idx low.
- Decode (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- PWM: digit enabled iff brightness == all-ones or pwm_cnt < brightness; disabled gives sel all ones (dout as decoded). brightness 0 gives sel all ones permanently.

## Timing
- Reset values: in_ready 1 (pending 0), dout 7'h7F, dp_n 1, sel all ones, frame_done 0; cnt, idx, pwm_cnt, blink counter, phase, act_*, pend_* all 0.
- dout, dp_n, sel, frame_done are registered; outputs reflect scan state (idx, pwm_cnt, masks) with one cycle latency.
- Load-to-display latency: up to one frame (NUM_DIGITS*CYCLE_PER_DIGIT cycles) + 1 cycle; in_ready returns high the cycle after the boundary.
- Slot length exactly CYCLE_PER_DIGIT cycles; frame exactly NUM_DIGITS*CYCLE_PER_DIGIT; frame_done period equal to frame length.
- Blink half-period = BLINK_FRAMES frames.
- rstn low mid-frame or with load pending: all state returns to reset values next edge; pending value discarded.

## Test plan
- NUM_DIGITS=8, CYCLE_PER_DIGIT=4, brightness all-ones: load 0x89ABCDEF -> sel steps FE,FD,...,7F every 4 cycles; digit0 dout 0x0E, digit7 dout 0x00; frame_done every 32 cycles.
- Load 0x12345678 mid-frame, then assert in_valid with 0x0 while in_ready low -> in_ready low until boundary, act becomes 0x12345678 at boundary, second value not accepted until in_ready high.
- lz_suppress=1, load 0x00000100 -> digits 7..3 dark (dout 7F, dp_n 1), digits 2..0 show 1,0,0; load 0 -> only digit 0 shows 0x40.
- blink_mask=0x01, BLINK_FRAMES=2 -> digit 0 dark for frames 2-3, lit for 0-1 and 4-5; blank_mask=0x80 -> digit 7 always dark; in_dp=0x02 -> dp_n low only in slot 1.
- BRIGHT_W=4, brightness=4 -> sel low 4 of every 16 cycles within its slot; brightness=0 -> sel stays all ones.
- Assert rstn low mid-frame with pending load -> next edge: sel all ones, dout 7F, in_ready 1, frame_done 0; scan restarts at digit 0 showing 0 (dout 0x40) after release.

Source files
------------

// File: rtl/multi_digit_ssd_if.sv
// rtl/multi_digit_ssd_if.sv - valid/ready load port for the seven-segment display driver
interface multi_digit_ssd_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] in_value;
    logic [NUM_DIGITS-1:0]   in_dp;

    modport master (
        output in_valid,
        output in_value,
        output in_dp,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  in_dp,
        output in_ready
    );
endinterface

// File: rtl/multi_digit_ssd.sv
// rtl/multi_digit_ssd.sv - time-multiplexed N-digit common-anode seven-segment driver
module multi_digit_ssd #(
    parameter int NUM_DIGITS      = 8,
    parameter int CYCLE_PER_DIGIT = 100000,
    parameter int BRIGHT_W        = 4,
    parameter int BLINK_FRAMES    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    multi_digit_ssd_if.slave      load,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            dout,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] sel,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(CYCLE_PER_DIGIT);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*NUM_DIGITS-1:0] pend_val, act_val;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic                    pending;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [BLK_W-1:0]        blk_cnt;
    logic                    phase;

    logic                    slot_end, boundary;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_dark, pwm_en;
    logic [NUM_DIGITS-1:0]   sel_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign load.in_ready = ~pending;
    assign slot_end      = (cnt == CNT_W'(CYCLE_PER_DIGIT - 1));
    assign boundary      = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign pwm_en        = (brightness == '1) || (pwm_cnt < brightness);

    // upper_zero[i]: every displayed nibble from digit i upward is zero
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_zero[i] = ((act_val >> (4 * i)) == '0);
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        sel_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib  = act_val[4*i +: 4];
                cur_dp   = act_dp[i];
                cur_dark = blank_mask[i] || (blink_mask[i] && phase) ||
                           (lz_suppress && (i != 0) && upper_zero[i]);
                sel_next[i] = ~pwm_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            pending    <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            pwm_cnt    <= '0;
            blk_cnt    <= '0;
            phase      <= 1'b0;
            dout       <= 7'h7F;
            dp_n       <= 1'b1;
            sel        <= '1;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // A load accepted on the boundary cycle waits for the next boundary
            if (boundary && pending) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                pending <= 1'b0;
            end else if (load.in_valid && !pending) begin
                pend_val <= load.in_value;
                pend_dp  <= load.in_dp;
                pending  <= 1'b1;
            end

            if (boundary) begin
                if (blk_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blk_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    blk_cnt <= blk_cnt + BLK_W'(1);
                end
            end

            dout       <= cur_dark ? 7'h7F : decode(cur_nib);
            dp_n       <= cur_dark ? 1'b1 : ~cur_dp;
            sel        <= sel_next;
            frame_done <= boundary;
        end
    end
endmodule
